// File: rtl/stopwatch_timebase_bcd.sv
`default_nettype none
// ============================================================================
// Module   : stopwatch_timebase_bcd
// Purpose  : Stopwatch core with a clock prescaler, a run/pause/clear control
//            FSM and a cascaded BCD counter MM:SS:CC.
//            Optional lap-hold stage is enabled with STOPWATCH_LAP_EN.
// Ports    : clk, rst         - clock, synchronous active-high reset
//            ena              - global enable; low freezes all state
//            start_stop       - one-cycle pulse, toggles run/pause
//            clear            - one-cycle pulse, zero counter and stop
//            lap              - one-cycle pulse, freeze/refresh outputs
//                               (present only with STOPWATCH_LAP_EN)
//            speed            - level, 1 selects FAST_DIV
//            running          - 1 while in RUN
//            tick, overflow   - one-cycle pulses on centisecond update / wrap
//            min_t..cs_o      - BCD digits
// Revision : 1.0 - initial release
// ============================================================================
module stopwatch_timebase_bcd #(
    parameter int TICK_DIV = 100000,
    parameter int FAST_DIV = 1000,
    parameter int MAX_MIN  = 59,
    parameter int PRESC_W  = 17
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       start_stop,
    input  logic       clear,
`ifdef STOPWATCH_LAP_EN
    input  logic       lap,
`endif
    input  logic       speed,
    output logic       running,
    output logic       tick,
    output logic       overflow,
    output logic [3:0] min_t,
    output logic [3:0] min_o,
    output logic [3:0] sec_t,
    output logic [3:0] sec_o,
    output logic [3:0] cs_t,
    output logic [3:0] cs_o
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_run   = 2'd1;
    localparam logic [1:0] c_st_pause = 2'd2;

    localparam logic [PRESC_W-1:0] c_lim_norm  = PRESC_W'(TICK_DIV - 1);
    localparam logic [PRESC_W-1:0] c_lim_fast  = PRESC_W'(FAST_DIV - 1);
    localparam logic [3:0]         c_max_min_t = 4'(MAX_MIN / 10);
    localparam logic [3:0]         c_max_min_o = 4'(MAX_MIN % 10);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic               r_running;
    logic               r_tick;
    logic               r_ovf;
    logic [PRESC_W-1:0] r_presc;
    logic [3:0]         r_min_t, r_min_o, r_sec_t, r_sec_o, r_cs_t, r_cs_o;

    logic               w_count;
    logic               w_presc_done;
    logic               w_adv;
    logic [PRESC_W-1:0] w_lim;
    logic               w_cs_o_max, w_cs_max, w_sec_o_max, w_sec_max, w_min_max;
    logic               w_roll;
    logic [23:0]        w_live;
    logic [23:0]        w_disp;

    // ------------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (ena) begin
            if (clear) begin
                w_state_nxt = c_st_idle;
            end else if (start_stop) begin
                case (r_state)
                    c_st_idle:  w_state_nxt = c_st_run;
                    c_st_run:   w_state_nxt = c_st_pause;
                    c_st_pause: w_state_nxt = c_st_run;
                    default:    w_state_nxt = c_st_idle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_running <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_running <= (w_state_nxt == c_st_run);
        end
    end

    // ------------------------------------------------------------------------
    // Prescaler and carry detection
    // ------------------------------------------------------------------------
    // Counting needs RUN both now and next cycle: the start cycle does not
    // count (so the first tick lands L+1 edges later) and the pausing cycle
    // does not consume a prescaler step (so resume continues exactly).
    assign w_count      = ena && (r_state == c_st_run) && (w_state_nxt == c_st_run);
    assign w_lim        = speed ? c_lim_fast : c_lim_norm;
    // >= rather than == so a switch to the shorter limit mid-count still wraps.
    assign w_presc_done = (r_presc >= w_lim);
    assign w_adv        = w_count && w_presc_done;

    assign w_cs_o_max  = (r_cs_o == 4'd9);
    assign w_cs_max    = w_cs_o_max && (r_cs_t == 4'd9);
    assign w_sec_o_max = (r_sec_o == 4'd9);
    assign w_sec_max   = w_sec_o_max && (r_sec_t == 4'd5);
    assign w_min_max   = (r_min_t == c_max_min_t) && (r_min_o == c_max_min_o);
    assign w_roll      = w_cs_max && w_sec_max && w_min_max;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_tick  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_tick <= w_adv;
            r_ovf  <= w_adv && w_roll;
            if (ena && clear) begin
                r_presc <= '0;
            end else if (w_count) begin
                if (w_presc_done) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + PRESC_W'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Cascaded BCD digits; the full wrap falls out of each digit rolling to 0
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || (ena && clear)) begin
            r_min_t <= 4'd0;
            r_min_o <= 4'd0;
            r_sec_t <= 4'd0;
            r_sec_o <= 4'd0;
            r_cs_t  <= 4'd0;
            r_cs_o  <= 4'd0;
        end else if (w_adv) begin
            r_cs_o <= w_cs_o_max ? 4'd0 : r_cs_o + 4'd1;
            if (w_cs_o_max) begin
                r_cs_t <= (r_cs_t == 4'd9) ? 4'd0 : r_cs_t + 4'd1;
            end
            if (w_cs_max) begin
                r_sec_o <= w_sec_o_max ? 4'd0 : r_sec_o + 4'd1;
                if (w_sec_o_max) begin
                    r_sec_t <= (r_sec_t == 4'd5) ? 4'd0 : r_sec_t + 4'd1;
                end
            end
            if (w_cs_max && w_sec_max) begin
                if (w_min_max) begin
                    r_min_t <= 4'd0;
                    r_min_o <= 4'd0;
                end else if (r_min_o == 4'd9) begin
                    r_min_o <= 4'd0;
                    r_min_t <= r_min_t + 4'd1;
                end else begin
                    r_min_o <= r_min_o + 4'd1;
                end
            end
        end
    end

    assign w_live = {r_min_t, r_min_o, r_sec_t, r_sec_o, r_cs_t, r_cs_o};

    // ------------------------------------------------------------------------
    // Optional lap hold stage
    // ------------------------------------------------------------------------
`ifdef STOPWATCH_LAP_EN
    logic        r_frozen;
    logic [23:0] r_hold;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_frozen <= 1'b0;
            r_hold   <= '0;
        end else if (ena) begin
            // Release wins over a coincident lap so a pause always shows live.
            if (clear || ((r_state == c_st_run) && (w_state_nxt == c_st_pause))) begin
                r_frozen <= 1'b0;
            end else if (lap && (r_state == c_st_run)) begin
                r_frozen <= 1'b1;
                r_hold   <= w_live;
            end
        end
    end

    assign w_disp = r_frozen ? r_hold : w_live;
`else
    assign w_disp = w_live;
`endif

    assign {min_t, min_o, sec_t, sec_o, cs_t, cs_o} = w_disp;
    assign running  = r_running;
    // Pulses are masked while disabled so a frozen block never reports events.
    assign tick     = r_tick && ena;
    assign overflow = r_ovf && ena;

endmodule
`default_nettype wire
